i2c_ccd_slave_model: RTL and testbench

//  I2C target (responder) for the CCD config bus: the far end of the I2C write master.

---
 rtl/i2c_ccd_slave_model.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_i2c_ccd_slave_model.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_ccd_slave_model.sv
// ---------------------------------------------------------------------------------------------
// i2c_ccd_slave_model
//
// I2C target for the CCD configuration bus. SCL/SDA are oversampled on iCLK, START/STOP are
// decoded, a 7-bit device address is matched, and [SUB_ADDR, DATA...] write sequences are
// presented on a simple register write port. Usable as a sensor stand-in or an on-FPGA target.
//
// Optional feature macro: I2C_SLAVE_READ_EN
//   defined     : reads (R/W=1) to DEV_ADDR are ACKed and served from iREG_RDATA.
//   not defined : iREG_RDATA is ignored and read addresses are NACKed.
//
// Parameters
//   DEV_ADDR     7-bit device address (8'hBA write / 8'hBB read on the wire)
//   SYNC_STAGES  flops in each SCL/SDA input synchroniser (>= 2)
//
// Ports
//   iCLK        in     system clock (>= 16x SCL rate)
//   iRST_N      in     asynchronous active-low reset
//   I2C_SCLK    in     I2C clock from the master
//   I2C_SDAT    inout  I2C data, only ever driven 1'b0 or released (1'bz)
//   oREG_ADDR   out 8  sub-address pointer
//   oREG_WDATA  out 8  last received data byte
//   oREG_WE     out    single-cycle write strobe qualifying oREG_ADDR/oREG_WDATA
//   iREG_RDATA  in  8  read data for oREG_ADDR (read feature only)
//   oBUSY       out    high from START until STOP
// ---------------------------------------------------------------------------------------------
module i2c_ccd_slave_model #(
    parameter logic [6:0]  DEV_ADDR    = 7'h5D,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic [7:0] oREG_ADDR,
    output logic [7:0] oREG_WDATA,
    output logic       oREG_WE,
    input  logic [7:0] iREG_RDATA,
    output logic       oBUSY
);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StSub,
        StSubAck,
        StWdata,
        StWdataAck,
        StIgnore
`ifdef I2C_SLAVE_READ_EN
        ,
        StRdata,
        StRdMack
`endif
    } stateT;

    // ---------------------------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ---------------------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclSync;
    logic [SYNC_STAGES-1:0] sdaSync;
    logic                   sclPrev;
    logic                   sdaPrev;
    logic                   sclNow;
    logic                   sdaNow;

    // Synchronisers reset to 1 so a released bus does not look like an edge after reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sclSync <= '1;
            sdaSync <= '1;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclSync <= {sclSync[SYNC_STAGES-2:0], I2C_SCLK};
            sdaSync <= {sdaSync[SYNC_STAGES-2:0], I2C_SDAT};
            sclPrev <= sclNow;
            sdaPrev <= sdaNow;
        end
    end

    assign sclNow = sclSync[SYNC_STAGES-1];
    assign sdaNow = sdaSync[SYNC_STAGES-1];

    logic startEv;
    logic stopEv;
    logic sclRise;
    logic sclFall;

    // SDA edges are qualified with the current SCL level, so an SCL rise coinciding with an
    // SDA edge in the same sample is taken as START/STOP rather than as a data bit.
    assign startEv = sdaPrev & ~sdaNow & sclNow;
    assign stopEv  = ~sdaPrev & sdaNow & sclNow;
    assign sclRise = ~sclPrev & sclNow & ~startEv & ~stopEv;
    assign sclFall = sclPrev & ~sclNow;

    // ---------------------------------------------------------------------------------------
    // Protocol state
    // ---------------------------------------------------------------------------------------
    stateT       stateQ, stateD;
    logic [3:0]  bitCntQ, bitCntD;
    logic [7:0]  shiftQ, shiftD;
    logic        sdaLowQ, sdaLowD;
    logic [7:0]  addrQ, addrD;
    logic [7:0]  wdataQ, wdataD;
    logic        weQ, weD;
    logic        busyQ, busyD;
`ifdef I2C_SLAVE_READ_EN
    logic        mackOkQ, mackOkD;
`endif

    logic [7:0]  rxByte;
    logic        lastBit;
    logic        addrMatch;
    logic        ackBegin;
    logic        ackEnd;

    assign rxByte    = {shiftQ[6:0], sdaNow};
    assign lastBit   = (bitCntQ == 4'd7);
    assign addrMatch = (rxByte[7:1] == DEV_ADDR);
    // ACK slot: the first SCL fall in an ACK state starts driving, the second ends the slot.
    assign ackBegin  = sclFall & ~sdaLowQ;
    assign ackEnd    = sclFall & sdaLowQ;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stateQ  <= StIdle;
            bitCntQ <= 4'd0;
            shiftQ  <= 8'h00;
            sdaLowQ <= 1'b0;
            addrQ   <= 8'h00;
            wdataQ  <= 8'h00;
            weQ     <= 1'b0;
            busyQ   <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            mackOkQ <= 1'b0;
`endif
        end else begin
            stateQ  <= stateD;
            bitCntQ <= bitCntD;
            shiftQ  <= shiftD;
            sdaLowQ <= sdaLowD;
            addrQ   <= addrD;
            wdataQ  <= wdataD;
            weQ     <= weD;
            busyQ   <= busyD;
`ifdef I2C_SLAVE_READ_EN
            mackOkQ <= mackOkD;
`endif
        end
    end

    always_comb begin
        stateD  = stateQ;
        bitCntD = bitCntQ;
        shiftD  = shiftQ;
        sdaLowD = sdaLowQ;
        addrD   = addrQ;
        wdataD  = wdataQ;
        weD     = 1'b0;
        busyD   = busyQ;
`ifdef I2C_SLAVE_READ_EN
        mackOkD = mackOkQ;
`endif

        if (stopEv) begin
            // A partially shifted byte is simply dropped; the pointer is untouched.
            stateD  = StIdle;
            busyD   = 1'b0;
            sdaLowD = 1'b0;
            bitCntD = 4'd0;
        end else if (startEv) begin
            stateD  = StAddr;
            busyD   = 1'b1;
            sdaLowD = 1'b0;
            bitCntD = 4'd0;
        end else begin
            case (stateQ)
                StIdle, StIgnore: begin
                    sdaLowD = 1'b0;
                end

                StAddr: begin
                    if (sclRise) begin
                        shiftD  = rxByte;
                        bitCntD = bitCntQ + 4'd1;
                        if (lastBit) begin
                            bitCntD = 4'd0;
                            if (addrMatch && !rxByte[0]) begin
                                stateD = StAddrAck;
`ifdef I2C_SLAVE_READ_EN
                                mackOkD = 1'b0;
                            end else if (addrMatch && rxByte[0]) begin
                                stateD  = StAddrAck;
                                mackOkD = 1'b1;  // marks this ACK slot as a read setup
`endif
                            end else begin
                                stateD = StIgnore;
                            end
                        end
                    end
                end

                StAddrAck: begin
                    if (ackBegin) begin
                        sdaLowD = 1'b1;
                    end else if (ackEnd) begin
                        sdaLowD = 1'b0;
                        bitCntD = 4'd0;
                        stateD  = StSub;
`ifdef I2C_SLAVE_READ_EN
                        if (mackOkQ) begin
                            // First read bit goes out on the same fall that ends the ACK.
                            mackOkD = 1'b0;
                            sdaLowD = ~iREG_RDATA[7];
                            shiftD  = {iREG_RDATA[6:0], 1'b1};
                            stateD  = StRdata;
                        end
`endif
                    end
                end

                StSub: begin
                    if (sclRise) begin
                        shiftD  = rxByte;
                        bitCntD = bitCntQ + 4'd1;
                        if (lastBit) begin
                            bitCntD = 4'd0;
                            addrD   = rxByte;
                            stateD  = StSubAck;
                        end
                    end
                end

                StSubAck: begin
                    if (ackBegin) begin
                        sdaLowD = 1'b1;
                    end else if (ackEnd) begin
                        sdaLowD = 1'b0;
                        bitCntD = 4'd0;
                        stateD  = StWdata;
                    end
                end

                StWdata: begin
                    if (sclRise) begin
                        shiftD  = rxByte;
                        bitCntD = bitCntQ + 4'd1;
                        if (lastBit) begin
                            bitCntD = 4'd0;
                            wdataD  = rxByte;
                            weD     = 1'b1;
                            stateD  = StWdataAck;
                        end
                    end
                end

                StWdataAck: begin
                    if (ackBegin) begin
                        sdaLowD = 1'b1;
                    end else if (ackEnd) begin
                        // Pointer advances only once the byte has been fully acknowledged.
                        sdaLowD = 1'b0;
                        bitCntD = 4'd0;
                        addrD   = addrQ + 8'd1;
                        stateD  = StWdata;
                    end
                end

`ifdef I2C_SLAVE_READ_EN
                StRdata: begin
                    if (sclRise) begin
                        bitCntD = bitCntQ + 4'd1;
                    end else if (sclFall) begin
                        if (bitCntQ == 4'd8) begin
                            sdaLowD = 1'b0;
                            bitCntD = 4'd0;
                            mackOkD = 1'b0;
                            stateD  = StRdMack;
                        end else begin
                            sdaLowD = ~shiftQ[7];
                            shiftD  = {shiftQ[6:0], 1'b1};
                        end
                    end
                end

                StRdMack: begin
                    if (sclRise) begin
                        if (!sdaNow) begin
                            addrD   = addrQ + 8'd1;
                            mackOkD = 1'b1;
                        end else begin
                            stateD = StIgnore;
                        end
                    end else if (sclFall && mackOkQ) begin
                        // iREG_RDATA already reflects the advanced pointer here.
                        mackOkD = 1'b0;
                        bitCntD = 4'd0;
                        sdaLowD = ~iREG_RDATA[7];
                        shiftD  = {iREG_RDATA[6:0], 1'b1};
                        stateD  = StRdata;
                    end
                end
`endif

                default: begin
                    stateD  = StIdle;
                    sdaLowD = 1'b0;
                end
            endcase
        end
    end

`ifndef I2C_SLAVE_READ_EN
    logic unusedBits;
    assign unusedBits = ^{iREG_RDATA, shiftQ[7]};
`endif

    // Open-drain: never drive a 1. sdaLowQ is cleared asynchronously by reset.
    assign I2C_SDAT   = sdaLowQ ? 1'b0 : 1'bz;
    assign oREG_ADDR  = addrQ;
    assign oREG_WDATA = wdataQ;
    assign oREG_WE    = weQ;
    assign oBUSY      = busyQ;

endmodule

// File: tb/tb_i2c_ccd_slave_model.sv
module tb_i2c_ccd_slave_model;

    localparam int Q = 8;  // iCLK cycles per quarter SCL period

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       sclDrv = 1'b1;
    logic       sdaRel = 1'b1;
    logic [7:0] iREG_RDATA = 8'h00;
    wire        sdaBus;
    logic [7:0] oREG_ADDR;
    logic [7:0] oREG_WDATA;
    logic       oREG_WE;
    logic       oBUSY;

    assign sdaBus = sdaRel ? 1'bz : 1'b0;
    pullup (sdaBus);

    always #5 iCLK = ~iCLK;

    i2c_ccd_slave_model dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .I2C_SCLK   (sclDrv),
        .I2C_SDAT   (sdaBus),
        .oREG_ADDR  (oREG_ADDR),
        .oREG_WDATA (oREG_WDATA),
        .oREG_WE    (oREG_WE),
        .iREG_RDATA (iREG_RDATA),
        .oBUSY      (oBUSY)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } weT;

    int         nVec = 0;
    int         nErr = 0;
    int         weCount = 0;
    weT         expWe[$];
    logic [7:0] modelPtr = 8'h00;
    logic       busyExp = 1'b0;
    logic       busyKnown = 1'b1;
    logic       prevWe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every write strobe against the model queue, busy whenever settled.
    always @(negedge iCLK) begin
        weT e;
        if (iRST_N && oREG_WE) begin
            weCount++;
            check("we_single_cycle", {31'd0, prevWe}, 32'd0);
            if (expWe.size() == 0) begin
                nVec++;
                nErr++;
                $display("FAIL we_unexpected: got addr %0h data %0h expected no strobe",
                         oREG_ADDR, oREG_WDATA);
            end else begin
                e = expWe.pop_front();
                check("we_addr", {24'd0, oREG_ADDR}, {24'd0, e.a});
                check("we_data", {24'd0, oREG_WDATA}, {24'd0, e.d});
            end
        end
        if (busyKnown) check("busy", {31'd0, oBUSY}, {31'd0, busyExp});
        prevWe = oREG_WE;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic mStart();
        sdaRel = 1'b1;
        tick(Q);
        sclDrv = 1'b1;
        tick(Q);
        busyKnown = 1'b0;
        sdaRel = 1'b0;
        tick(Q);
        busyExp = 1'b1;
        busyKnown = 1'b1;
        sclDrv = 1'b0;
        tick(Q);
    endtask

    task automatic mStop();
        sdaRel = 1'b0;
        tick(Q);
        sclDrv = 1'b1;
        tick(Q);
        busyKnown = 1'b0;
        sdaRel = 1'b1;
        tick(Q);
        busyExp = 1'b0;
        busyKnown = 1'b1;
        tick(Q);
    endtask

    task automatic mBit(input logic b);
        sdaRel = b;
        tick(Q);
        sclDrv = 1'b1;
        tick(2 * Q);
        sclDrv = 1'b0;
        tick(Q);
    endtask

    // Sends a byte and checks the target's ACK (expAck=1 means SDA must be pulled low).
    task automatic mByte(input string name, input logic [7:0] b, input logic expAck);
        for (int i = 7; i >= 0; i--) mBit(b[i]);
        sdaRel = 1'b1;
        tick(Q);
        sclDrv = 1'b1;
        tick(Q);
        check(name, {31'd0, sdaBus}, {31'd0, ~expAck});
        tick(Q);
        sclDrv = 1'b0;
        tick(Q);
    endtask

    // Model of a whole write transaction: only an exact write address is acknowledged;
    // byte 1 sets the pointer, each later byte is one write at the pointer, then pointer+1.
    task automatic mWrite(input string tag, input logic [31:0] msg, input int n);
        logic       ok;
        logic [7:0] b;
        mStart();
        b  = msg[31:24];
        ok = (b == 8'hBA);
        mByte({tag, "_ack_addr"}, b, ok);
        for (int i = 1; i < n; i++) begin
            b = msg[31 - 8 * i -: 8];
            if (ok && i == 1) begin
                modelPtr = b;
            end else if (ok) begin
                expWe.push_back(weT'({modelPtr, b}));
                modelPtr = modelPtr + 8'd1;
            end
            mByte({tag, "_ack_byte"}, b, ok);
        end
        mStop();
        check({tag, "_ptr"}, {24'd0, oREG_ADDR}, {24'd0, modelPtr});
        check({tag, "_we_pending"}, expWe.size(), 32'd0);
    endtask

`ifdef I2C_SLAVE_READ_EN
    task automatic mReadByte(output logic [7:0] d, input logic mAck);
        for (int i = 7; i >= 0; i--) begin
            sdaRel = 1'b1;
            tick(Q);
            sclDrv = 1'b1;
            tick(Q);
            d[i] = sdaBus;
            tick(Q);
            sclDrv = 1'b0;
            tick(Q);
        end
        sdaRel = ~mAck;
        tick(Q);
        sclDrv = 1'b1;
        tick(2 * Q);
        sclDrv = 1'b0;
        tick(Q);
        sdaRel = 1'b1;
    endtask
`endif

    initial begin
        logic [7:0] rd;
        rd = 8'h00;

        // Reset state
        tick(3);
        check("rst_addr", {24'd0, oREG_ADDR}, 32'h00);
        check("rst_wdata", {24'd0, oREG_WDATA}, 32'h00);
        check("rst_we", {31'd0, oREG_WE}, 32'd0);
        check("rst_busy", {31'd0, oBUSY}, 32'd0);
        check("rst_sda", {31'd0, sdaBus}, 32'd1);
        iRST_N = 1'b1;
        tick(4);

        // Single write
        mWrite("wr1", {8'hBA, 8'h05, 8'h88, 8'h00}, 3);
        check("wr1_addr_lit", {24'd0, oREG_ADDR}, 32'h06);
        check("wr1_wdata_lit", {24'd0, oREG_WDATA}, 32'h88);
        check("wr1_we_count", weCount, 32'd1);

        // Wrong address: all NACK, nothing written
        mWrite("bad", {8'hB8, 8'h05, 8'h88, 8'h00}, 3);
        check("bad_addr_lit", {24'd0, oREG_ADDR}, 32'h06);
        check("bad_we_count", weCount, 32'd1);

        // Burst with pointer wrap
        mWrite("burst", {8'hBA, 8'hFF, 8'h11, 8'h22}, 4);
        check("burst_addr_lit", {24'd0, oREG_ADDR}, 32'h01);
        check("burst_wdata_lit", {24'd0, oREG_WDATA}, 32'h22);
        check("burst_we_count", weCount, 32'd3);

        // Truncated data byte then STOP
        mStart();
        mByte("part_ack_addr", 8'hBA, 1'b1);
        modelPtr = 8'h10;
        mByte("part_ack_sub", 8'h10, 1'b1);
        mBit(1'b1);
        mBit(1'b0);
        mBit(1'b1);
        mBit(1'b1);
        mStop();
        check("part_addr_lit", {24'd0, oREG_ADDR}, 32'h10);
        check("part_we_count", weCount, 32'd3);
        check("part_busy", {31'd0, oBUSY}, 32'd0);

`ifdef I2C_SLAVE_READ_EN
        // Read after repeated START, master NACK ends it
        iREG_RDATA = 8'hA5;
        mStart();
        mByte("rd_ack_addr", 8'hBA, 1'b1);
        mByte("rd_ack_sub", 8'h20, 1'b1);
        mStart();
        mByte("rd_ack_raddr", 8'hBB, 1'b1);
        mReadByte(rd, 1'b0);
        check("rd_data", {24'd0, rd}, 32'hA5);
        tick(Q);
        check("rd_sda_released", {31'd0, sdaBus}, 32'd1);
        mStop();
        modelPtr = 8'h20;
        check("rd_addr_lit", {24'd0, oREG_ADDR}, 32'h20);
        check("rd_we_count", weCount, 32'd3);
`else
        // Read address is NACKed without the read feature
        mStart();
        mByte("rd_nack", 8'hBB, 1'b0);
        mStop();
        check("rd_nack_addr", {24'd0, oREG_ADDR}, 32'h10);
        check("rd_nack_we_count", weCount, 32'd3);
`endif

        // Reset while the target holds SDA low for ACK
        mStart();
        for (int i = 7; i >= 0; i--) mBit(rd[0] ^ rd[0] ^ ((8'hBA >> i) & 8'h01) != 0);
        sdaRel = 1'b1;
        tick(Q);
        check("rst_mid_ack_low", {31'd0, sdaBus}, 32'd0);
        busyKnown = 1'b0;
        iRST_N = 1'b0;
        #1;
        check("rst_mid_sda", {31'd0, sdaBus}, 32'd1);
        check("rst_mid_busy", {31'd0, oBUSY}, 32'd0);
        check("rst_mid_addr", {24'd0, oREG_ADDR}, 32'h00);
        check("rst_mid_wdata", {24'd0, oREG_WDATA}, 32'h00);
        check("rst_mid_we", {31'd0, oREG_WE}, 32'd0);
        modelPtr = 8'h00;
        busyExp = 1'b0;
        tick(2);
        iRST_N = 1'b1;
        sclDrv = 1'b1;
        tick(Q);
        busyKnown = 1'b1;
        tick(Q);

        mWrite("post", {8'hBA, 8'h05, 8'h88, 8'h00}, 3);
        check("post_addr_lit", {24'd0, oREG_ADDR}, 32'h06);
        check("post_we_count", weCount, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
